platform_row_spawner: RTL and testbench

//  Downstream consumer of the seven_shifter/five_shifter pseudo-random pair. Every SPAWN_PERIOD

---
 rtl/platform_row_spawner_if.sv | 14 +
 rtl/platform_row_spawner.sv | 128 ++++++++++++
 tb/tb_platform_row_spawner.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_row_spawner_if.sv
// Row hand-off bus between platform_row_spawner (master) and the scroll/draw stage (slave).
// valid/ready: a row transfers on every clock edge where row_valid && row_ready; row_data holds while row_valid=1 and row_ready=0.
interface platform_row_spawner_if #(
  parameter int COLS  = 12,
  parameter int DEPTH = 4
);
  logic                     row_valid;
  logic                     row_ready;
  logic [COLS-1:0]          row_data;
  logic [$clog2(DEPTH):0]   row_count;

  modport master (output row_valid, output row_data, output row_count, input row_ready);
  modport slave  (input row_valid, input row_data, input row_count, output row_ready);
endinterface

// File: rtl/platform_row_spawner.sv
// Pulses the seven/five shifters every SPAWN_PERIOD frames, builds a platform row and queues it in an FWFT FIFO.
// Optional macro GAP_GUARANTEE_EN: an all-ones pattern gets a drop-through hole at column off+3.
module platform_row_spawner #(
  parameter int COLS         = 12,
  parameter int SPAWN_PERIOD = 4,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_run,
  input  logic                    i_frame_tick,
  input  logic [6:0]              i_pat7,
  input  logic [4:0]              i_lane5,
  output logic                    o_shift_en,
  output logic [2:0]              o_state,
  platform_row_spawner_if.master  o_row
);

  localparam int              CW      = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CW-1:0]   LAST    = CW'(SPAWN_PERIOD - 1);
  localparam logic [5:0]      MAX_OFF = 6'(COLS - 7);
  localparam logic [AW:0]     FULL_N  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_BUILD = 3'd3,
    S_PUSH  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [COLS-1:0] r_row, w_row_nxt;
  logic [COLS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_full, w_empty, w_push, w_pop;
  logic [5:0]      w_off;
  logic [COLS-1:0] w_row_built;

  assign w_full  = (r_count == FULL_N);
  assign w_empty = (r_count == '0);
  // Fullness is judged at cycle start, so a pop never lets the pending row bypass a full FIFO.
  assign w_push  = (r_state == S_PUSH) && !w_full;
  assign w_pop   = !w_empty && o_row.row_ready;

  // Offset is clamped so the 7-bit pattern always fits inside the row.
  always_comb begin
    w_off       = ({1'b0, i_lane5} > MAX_OFF) ? MAX_OFF : {1'b0, i_lane5};
    w_row_built = COLS'(i_pat7) << w_off;
`ifdef GAP_GUARANTEE_EN
    if (i_pat7 == 7'h7F)
      w_row_built = w_row_built & ~(COLS'(1) << (w_off + 6'd3));
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_frame_tick) begin
          if (r_cnt == LAST) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_SHIFT: w_state_nxt = S_BUILD;
      // The shifters advanced on the SHIFT edge, so their outputs are fresh here.
      S_BUILD: begin
        w_row_nxt   = w_row_built;
        w_state_nxt = S_PUSH;
      end
      S_PUSH: begin
        if (!w_full) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_row    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_push) r_mem[r_wr_ptr] <= r_row;
  end

  assign o_shift_en      = (r_state == S_SHIFT);
  assign o_state         = r_state;
  assign o_row.row_valid = !w_empty;
  assign o_row.row_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_row.row_count = r_count;

endmodule

// File: tb/tb_platform_row_spawner.sv
// Bench for platform_row_spawner: table of spawn vectors, random vectors, and hand sequences for stalls and resets.
module tb_platform_row_spawner;

  localparam int COLS = 12;
  localparam int SP   = 2;
  localparam int DEP  = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_PUSH  = 3'd4;

  logic       clk;
  logic       resetn;
  logic       run;
  logic       frame_tick;
  logic [6:0] pat7;
  logic [4:0] lane5;
  logic       shift_en;
  logic [2:0] state;

  platform_row_spawner_if #(.COLS(COLS), .DEPTH(DEP)) row_if ();

  platform_row_spawner #(.COLS(COLS), .SPAWN_PERIOD(SP), .DEPTH(DEP)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_run        (run),
    .i_frame_tick (frame_tick),
    .i_pat7       (pat7),
    .i_lane5      (lane5),
    .o_shift_en   (shift_en),
    .o_state      (state),
    .o_row        (row_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  pat;
    logic [4:0]  lane;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [11:0] exp_q [$];
  int          n_pass;
  int          n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_row(input logic [6:0] pat, input logic [4:0] lane);
    int          off;
    logic [11:0] r;
    off = (int'(lane) > COLS - 7) ? COLS - 7 : int'(lane);
    r   = 12'(pat) << off;
`ifdef GAP_GUARANTEE_EN
    if (pat == 7'h7F) r = r & ~(12'd1 << (off + 3));
`endif
    return r;
  endfunction

  // Two ticks from a zeroed counter; the shifters' new values appear on the edge after shift_en.
  // Returns one cycle after the shift cycle (FSM in BUILD).
  task automatic do_spawn(input logic [6:0] pat, input logic [4:0] lane, input logic [11:0] exp);
    int waited;
    pat7       = ~pat;
    lane5      = lane ^ 5'h15;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("shift_latency", {31'd0, shift_en}, 32'd1);
    waited = 0;
    while (!shift_en && waited < 8) begin
      step();
      waited++;
    end
    step();
    pat7  = pat;
    lane5 = lane;
    check("shift_pulse_width", {31'd0, shift_en}, 32'd0);
    exp_q.push_back(exp);
  endtask

  // Scoreboard pop: ready for one cycle, compare head against the expected queue.
  task automatic pop_check(input string name);
    logic [11:0] e;
    row_if.row_ready = 1'b1;
    #4;
    check({name, "_valid"}, {31'd0, row_if.row_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, {20'd0, row_if.row_data}, {20'd0, e});
    end
    @(posedge clk);
    #1;
    row_if.row_ready = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{7'h53, 5'd9,  12'hA60};
    vecs[1] = '{7'h01, 5'd0,  12'h001};
    vecs[2] = '{7'h40, 5'd5,  12'h800};
    vecs[3] = '{7'h2A, 5'd31, 12'h540};
    vecs[4] = '{7'h0F, 5'd2,  12'h03C};
`ifdef GAP_GUARANTEE_EN
    vecs[5] = '{7'h7F, 5'd0,  12'h077};
    vecs[6] = '{7'h7F, 5'd4,  12'h770};
    vecs[7] = '{7'h7F, 5'd7,  12'hEE0};
`else
    vecs[5] = '{7'h7F, 5'd0,  12'h07F};
    vecs[6] = '{7'h7F, 5'd4,  12'h7F0};
    vecs[7] = '{7'h7F, 5'd7,  12'hFE0};
`endif

    resetn           = 1'b0;
    run              = 1'b1;
    frame_tick       = 1'b0;
    pat7             = 7'd0;
    lane5            = 5'd0;
    row_if.row_ready = 1'b0;
    step();
    step();
    check("rst_shift_en",  {31'd0, shift_en}, 32'd0);
    check("rst_row_valid", {31'd0, row_if.row_valid}, 32'd0);
    check("rst_row_data",  {20'd0, row_if.row_data}, 32'd0);
    check("rst_row_count", {29'd0, row_if.row_count}, 32'd0);
    check("rst_state",     {29'd0, state}, {29'd0, ST_IDLE});
    resetn = 1'b1;
    step();
    check("run_to_wait", {29'd0, state}, {29'd0, ST_WAIT});

    // First spawn with exact latency: row appears three edges after the completing tick.
    do_spawn(7'b1010011, 5'd3, 12'h298);
    step();
    step();
    check("spawn_valid", {31'd0, row_if.row_valid}, 32'd1);
    check("spawn_data",  {20'd0, row_if.row_data}, 32'h298);
    check("spawn_count", {29'd0, row_if.row_count}, 32'd1);
    check("spawn_state", {29'd0, state}, {29'd0, ST_WAIT});
    pop_check("spawn_pop");
    check("empty_count", {29'd0, row_if.row_count}, 32'd0);
    check("empty_data",  {20'd0, row_if.row_data}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_spawn(vecs[i].pat, vecs[i].lane, vecs[i].exp);
      step();
      step();
      check("vec_count", {29'd0, row_if.row_count}, 32'd1);
      pop_check("vec");
    end

    for (int i = 0; i < 4; i++) begin
      logic [6:0] p;
      logic [4:0] l;
      p = 7'($urandom_range(0, 127));
      l = 5'($urandom_range(0, 31));
      do_spawn(p, l, model_row(p, l));
      step();
      step();
      pop_check("rand");
    end

    // ready while empty must not disturb anything
    row_if.row_ready = 1'b1;
    step();
    row_if.row_ready = 1'b0;
    check("ready_empty_count", {29'd0, row_if.row_count}, 32'd0);

    // Backpressure: fifth row stalls in PUSH and ticks are ignored.
    for (int i = 0; i < 5; i++) begin
      logic [6:0] p;
      logic [4:0] l;
      p = 7'($urandom_range(1, 127));
      l = 5'($urandom_range(0, 31));
      do_spawn(p, l, model_row(p, l));
      step();
      step();
    end
    check("bp_count", {29'd0, row_if.row_count}, 32'd4);
    check("bp_state", {29'd0, state}, {29'd0, ST_PUSH});
    for (int i = 0; i < 6; i++) begin
      frame_tick = (i % 2 == 0);
      step();
      check("bp_no_shift", {31'd0, shift_en}, 32'd0);
    end
    frame_tick = 1'b0;
    pop_check("bp_pop");
    check("bp_count_after_pop", {29'd0, row_if.row_count}, 32'd3);
    step();
    check("bp_count_refill", {29'd0, row_if.row_count}, 32'd4);
    check("bp_state_refill", {29'd0, state}, {29'd0, ST_WAIT});
    for (int i = 0; i < 4; i++) pop_check("bp_drain");
    check("bp_drained", {29'd0, row_if.row_count}, 32'd0);

    // Push and pop in the same cycle with one row queued.
    do_spawn(7'h11, 5'd1, 12'h022);
    step();
    step();
    do_spawn(7'h33, 5'd2, 12'h0CC);
    step();
    check("pp_state", {29'd0, state}, {29'd0, ST_PUSH});
    pop_check("pp_pop");
    check("pp_count", {29'd0, row_if.row_count}, 32'd1);
    pop_check("pp_pop2");

    // run dropped mid-flight: row still completes, then FSM leaves via WAIT to IDLE.
    do_spawn(7'h05, 5'd6, 12'h0A0);
    run = 1'b0;
    step();
    step();
    check("run0_count", {29'd0, row_if.row_count}, 32'd1);
    step();
    check("run0_idle", {29'd0, state}, {29'd0, ST_IDLE});
    for (int i = 0; i < 4; i++) begin
      frame_tick = (i % 2 == 0);
      step();
      check("run0_no_shift", {31'd0, shift_en}, 32'd0);
    end
    frame_tick = 1'b0;
    pop_check("run0_pop");
    run = 1'b1;
    step();

    // Reset in the PUSH cycle with two rows queued.
    for (int i = 0; i < 2; i++) begin
      do_spawn(7'h03, 5'(i), model_row(7'h03, 5'(i)));
      step();
      step();
    end
    do_spawn(7'h07, 5'd0, 12'h007);
    step();
    check("mid_state", {29'd0, state}, {29'd0, ST_PUSH});
    check("mid_count", {29'd0, row_if.row_count}, 32'd2);
    resetn = 1'b0;
    step();
    exp_q.delete();
    check("mid_rst_count", {29'd0, row_if.row_count}, 32'd0);
    check("mid_rst_valid", {31'd0, row_if.row_valid}, 32'd0);
    check("mid_rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    resetn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_shift", {31'd0, shift_en}, 32'd0);
    end
    check("mid_rst_stays_empty", {29'd0, row_if.row_count}, 32'd0);
    do_spawn(7'h21, 5'd4, 12'h210);
    step();
    step();
    pop_check("mid_recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
